hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage RV32I core. It consumes the register fields the ID-stage instruction decode produces each cycle. It keeps its own E/M/W shadow records of destination registers and drives stall, flush and forward selects for IF/ID/EX/MEM/WB. It also sequences data-memory wait states through a two-state FSM with a timeout counter.

---
 rtl/hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I core: stall, flush and forward selects plus data-memory wait sequencing.
// Latency: all outputs are combinational from registered E/M/W records and current inputs; a memory wait stalls every stage and never self-releases.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] RdD,
    input  logic       UseRs1D,
    input  logic       UseRs2D,
    input  logic       RegWriteD,
    input  logic       LoadD,
    input  logic       BranchTakenE,
    input  logic       DmemReqM,
    input  logic       DmemReadyM,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MemTimeout
);

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       regwrite;
        logic       load;
    } rec_t;

    // WB keeps only the fields the forwarding compare reads.
    typedef struct packed {
        logic [4:0] rd;
        logic       regwrite;
    } wrec_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(MEM_TIMEOUT);

    rec_t        e_q, e_d, m_q, m_d;
    wrec_t       w_q, w_d;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;

    logic w8;
    logic load_use;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input rec_t m, input wrec_t w);
        logic [1:0] sel;
        sel = 2'b00;
        if (m.regwrite && (m.rd != 5'd0) && (m.rd == src) && !m.load) begin
            sel = 2'b10;
        end else if (w.regwrite && (w.rd != 5'd0) && (w.rd == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        w8       = DmemReqM && !DmemReadyM;
        load_use = e_q.load && (e_q.rd != 5'd0) &&
                   ((UseRs1D && (Rs1D == e_q.rd)) || (UseRs2D && (Rs2D == e_q.rd)));

        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;

        // A taken branch during a wait is deferred: E holds it until the wait ends.
        if (w8) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (BranchTakenE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end

        e_d = e_q;
        m_d = m_q;
        w_d = '0;
        if (!w8) begin
            w_d = '{rd: m_q.rd, regwrite: m_q.regwrite};
            m_d = e_q;
            if (flush_e) begin
                e_d = '0;
            end else begin
                e_d = '{rd: RdD, rs1: Rs1D, rs2: Rs2D,
                        regwrite: RegWriteD && (RdD != 5'd0), load: LoadD};
            end
        end

        state_d = w8 ? MEM_WAIT : RUN;
        cnt_d   = 16'd0;
        if (w8) begin
            if (state_q == RUN) begin
                cnt_d = 16'd1;
            end else if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end
        timeout_d = timeout_q || (w8 && (cnt_d == TIMEOUT_LIM));
    end

    always_comb begin
        StallF     = stall_f && !reset;
        StallD     = stall_d && !reset;
        StallE     = stall_e && !reset;
        StallM     = stall_m && !reset;
        FlushD     = flush_d && !reset;
        FlushE     = flush_e && !reset;
        FlushW     = flush_w && !reset;
        ForwardAE  = reset ? 2'b00 : fwd_sel(e_q.rs1, m_q, w_q);
        ForwardBE  = reset ? 2'b00 : fwd_sel(e_q.rs2, m_q, w_q);
        MemTimeout = timeout_q && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q       <= '0;
            m_q       <= '0;
            w_q       <= '0;
            state_q   <= RUN;
            cnt_q     <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            e_q       <= e_d;
            m_q       <= m_d;
            w_q       <= w_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch, memory wait, timeout and reset cases.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, RdD;
    logic       UseRs1D, UseRs2D, RegWriteD, LoadD;
    logic       BranchTakenE, DmemReqM, DmemReadyM;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       MemTimeout;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .UseRs1D(UseRs1D), .UseRs2D(UseRs2D), .RegWriteD(RegWriteD), .LoadD(LoadD),
        .BranchTakenE(BranchTakenE), .DmemReqM(DmemReqM), .DmemReadyM(DmemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemTimeout(MemTimeout)
    );

    always #5 clk = ~clk;

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    wire [6:0] ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go();
        #2;
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; RdD = 0;
        UseRs1D = 0; UseRs2D = 0; RegWriteD = 0; LoadD = 0;
        BranchTakenE = 0; DmemReqM = 0; DmemReadyM = 0;
    endtask

    task automatic set_id(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic rw, input logic ld);
        RdD = rd; Rs1D = rs1; Rs2D = rs2;
        UseRs1D = u1; UseRs2D = u2; RegWriteD = rw; LoadD = ld;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        // Reset held with active-looking inputs: outputs must be forced low.
        DmemReqM = 1'b1;
        tick();
        go();
        chk("rst_ctl", 16'(ctl), 16'h0);
        chk("rst_fwd", {12'd0, ForwardAE, ForwardBE}, 16'h0);
        tick();
        reset = 1'b0;
        idle();
        go();
        chk("post_rst_ctl", 16'(ctl), 16'h0);
        chk("post_rst_tmo", 16'(MemTimeout), 16'h0);

        // add x5 -> consumer (x7) reads x5 -> second consumer reads x5
        set_id(5, 1, 2, 1, 1, 1, 0);
        tick();
        set_id(7, 5, 3, 1, 1, 1, 0);
        go();
        chk("fw_c1_ctl", 16'(ctl), 16'h0);
        tick();
        set_id(12, 5, 0, 1, 0, 1, 0);
        go();
        chk("fw_mem_a", 16'(ForwardAE), 16'h2);
        chk("fw_mem_b", 16'(ForwardBE), 16'h0);
        tick();
        idle();
        go();
        chk("fw_wb_a", 16'(ForwardAE), 16'h1);
        chk("fw_wb_ctl", 16'(ctl), 16'h0);
        tick();

        // lw x6 followed by a reader of x6 on rs2
        set_id(6, 1, 0, 1, 0, 1, 1);
        tick();
        set_id(8, 0, 6, 0, 1, 1, 0);
        go();
        chk("lu_ctl", 16'(ctl), 16'b1100010);
        tick();
        go();
        chk("lu_once_ctl", 16'(ctl), 16'h0);
        tick();
        idle();
        go();
        chk("lu_fwd_b", 16'(ForwardBE), 16'h1);
        tick();

        // Load into x0 never creates a load-use hazard
        set_id(0, 1, 0, 1, 0, 1, 1);
        tick();
        set_id(8, 0, 0, 0, 1, 1, 0);
        go();
        chk("lu_x0_ctl", 16'(ctl), 16'h0);
        tick();

        // Taken branch coincident with load-use match
        set_id(9, 1, 0, 1, 0, 1, 1);
        tick();
        set_id(10, 9, 0, 1, 0, 1, 0);
        BranchTakenE = 1'b1;
        go();
        chk("br_lu_ctl", 16'(ctl), 16'b0000110);
        tick();
        idle();
        tick();

        // Three wait cycles with a pending taken branch, then ready
        DmemReqM = 1'b1;
        DmemReadyM = 1'b0;
        BranchTakenE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            go();
            chk($sformatf("wait%0d_ctl", i), 16'(ctl), 16'b1111001);
            tick();
        end
        DmemReadyM = 1'b1;
        go();
        chk("ready_ctl", 16'(ctl), 16'b0000110);
        chk("ready_tmo", 16'(MemTimeout), 16'h0);
        tick();
        idle();
        tick();

        // Timeout of 4 wait cycles
        DmemReqM = 1'b1;
        DmemReadyM = 1'b0;
        repeat (3) tick();
        go();
        chk("tmo_3", 16'(MemTimeout), 16'h0);
        tick();
        go();
        chk("tmo_4", 16'(MemTimeout), 16'h1);
        chk("tmo_4_ctl", 16'(ctl), 16'b1111001);
        DmemReadyM = 1'b1;
        go();
        chk("tmo_ready", 16'(MemTimeout), 16'h1);
        tick();
        idle();
        go();
        chk("tmo_sticky", 16'(MemTimeout), 16'h1);
        tick();

        // Build a forwarding pair, then reset in the middle of a wait
        set_id(10, 1, 2, 1, 1, 1, 0);
        tick();
        set_id(11, 10, 0, 1, 0, 1, 0);
        tick();
        idle();
        DmemReqM = 1'b1;
        go();
        chk("hold_fwd_a0", 16'(ForwardAE), 16'h2);
        tick();
        go();
        chk("hold_fwd_a1", 16'(ForwardAE), 16'h2);
        chk("hold_ctl", 16'(ctl), 16'b1111001);
        reset = 1'b1;
        go();
        chk("rst_mid_ctl", 16'(ctl), 16'h0);
        chk("rst_mid_tmo", 16'(MemTimeout), 16'h0);
        tick();
        reset = 1'b0;
        DmemReqM = 1'b0;
        go();
        chk("after_rst_ctl", 16'(ctl), 16'h0);
        chk("after_rst_fwd", {12'd0, ForwardAE, ForwardBE}, 16'h0);
        chk("after_rst_tmo", 16'(MemTimeout), 16'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
